small_cpu_core: RTL and testbench

SMALL_CPU_CORE -- requirements
Module: small_cpu_core

---
 rtl/small_cpu_pkg.sv | 14 +
 rtl/small_cpu_regfile.sv | 28 ++
 rtl/small_cpu_core.sv | 170 +++++++++++++++++
 tb/tb_small_cpu_core.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/small_cpu_pkg.sv
// Shared opcode/sub-op encodings and FSM state type for the small CPU core.
package small_cpu_pkg;
  localparam logic [1:0] OP_SYS = 2'b00;
  localparam logic [1:0] OP_LD  = 2'b01;
  localparam logic [1:0] OP_ST  = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  localparam logic [1:0] SUB_NOP  = 2'b00;
  localparam logic [1:0] SUB_HALT = 2'b01;
  localparam logic [1:0] SUB_JMP  = 2'b10;
  localparam logic [1:0] SUB_JZ   = 2'b11;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_e;
endpackage

// File: rtl/small_cpu_regfile.sv
// 4-entry register file: two async read ports, one sync write port, async active-low clear.
module small_cpu_regfile #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [1:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b
);
  logic [3:0][DATA_W-1:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];
endmodule

// File: rtl/small_cpu_core.sv
// Multi-cycle 8-bit-instruction CPU core: FETCH/EXEC/MEM/HALT with req/ack memory ports.
// Define SMALL_CPU_CARRY_EN to make ADD consume and produce the carry flag.
module small_cpu_core
  import small_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [3:0]        dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              halted,
  output logic              carry
);
  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic              imem_req_q, imem_req_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [3:0]        dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
  logic              halted_q, halted_d;

  logic              rf_we;
  logic [1:0]        rf_waddr, rf_raddr_a;
  logic [DATA_W-1:0] rf_wdata, rd_a, rd_b, add_res;
  logic [1:0]        op, sub;
  logic signed [3:0] off4;
  logic [PC_W-1:0]   jmp_tgt;

  assign op      = ir_q[7:6];
  assign sub     = ir_q[5:4];
  assign off4    = ir_q[3:0];
  assign jmp_tgt = pc_q + PC_W'(off4);
  // Port A serves ADD's first operand, JZ's r3 test, and ST's source register.
  assign rf_raddr_a = (op == OP_ADD) ? ir_q[3:2] : (op == OP_SYS) ? 2'd3 : ir_q[5:4];

`ifdef SMALL_CPU_CARRY_EN
  logic carry_q, carry_d, add_co;
  assign {add_co, add_res} = {1'b0, rd_a} + {1'b0, rd_b} + {{DATA_W{1'b0}}, carry_q};
  assign carry = carry_q;
`else
  assign add_res = rd_a + rd_b;
  assign carry   = 1'b0;
`endif

  small_cpu_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk(clk), .rst_n(reset), .we(rf_we), .waddr(rf_waddr), .wdata(rf_wdata),
    .raddr_a(rf_raddr_a), .rdata_a(rd_a), .raddr_b(ir_q[1:0]), .rdata_b(rd_b)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    imem_req_d   = imem_req_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    halted_d     = halted_q;
    rf_we        = 1'b0;
    rf_waddr     = ir_q[5:4];
    rf_wdata     = dmem_rdata;
`ifdef SMALL_CPU_CARRY_EN
    carry_d      = carry_q;
`endif
    case (state_q)
      FETCH: begin
        imem_req_d = 1'b1;
        if (imem_req_q && imem_ack) begin
          ir_d       = imem_rdata;
          pc_d       = pc_q + 1'b1;
          imem_req_d = 1'b0;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        state_d    = FETCH;
        imem_req_d = 1'b1;
        case (op)
          OP_SYS: case (sub)
            SUB_HALT: begin
              state_d    = HALT;
              imem_req_d = 1'b0;
              halted_d   = 1'b1;
            end
            SUB_JMP: pc_d = jmp_tgt;
            SUB_JZ:  if (rd_a == '0) pc_d = jmp_tgt;
            default: ;
          endcase
          OP_LD, OP_ST: begin
            state_d      = MEM;
            imem_req_d   = 1'b0;
            dmem_req_d   = 1'b1;
            dmem_we_d    = (op == OP_ST);
            dmem_addr_d  = ir_q[3:0];
            dmem_wdata_d = rd_a;
          end
          default: begin
            rf_we    = 1'b1;
            rf_waddr = 2'd3;
            rf_wdata = add_res;
`ifdef SMALL_CPU_CARRY_EN
            carry_d  = add_co;
`endif
          end
        endcase
      end
      MEM: begin
        if (dmem_req_q && dmem_ack) begin
          rf_we      = !dmem_we_q;
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          imem_req_d = 1'b1;
          state_d    = FETCH;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FETCH;
      pc_q         <= '0;
      ir_q         <= '0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      halted_q     <= 1'b0;
`ifdef SMALL_CPU_CARRY_EN
      carry_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      halted_q     <= halted_d;
`ifdef SMALL_CPU_CARRY_EN
      carry_q      <= carry_d;
`endif
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign halted     = halted_q;
endmodule

// File: tb/tb_small_cpu_core.sv
// Directed bench for small_cpu_core with behavioural imem/dmem responders.
module tb_small_cpu_core;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted, carry;
  logic [7:0] imem_addr, imem_rdata, dmem_wdata, dmem_rdata;
  logic [3:0] dmem_addr;

  logic [7:0] imem [256];
  logic [7:0] dmem [16];
  int         dmem_lat = 0;
  int         dmem_cnt = 0;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] f_addr[$];
  int         f_cyc[$];
  logic [3:0] w_addr[$];
  logic [7:0] w_data[$];
  logic       w_carry[$];

  small_cpu_core #(.DATA_W(8), .PC_W(8)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .halted(halted), .carry(carry)
  );

  always #5 clk = ~clk;

  assign imem_ack   = imem_req;
  assign imem_rdata = imem[imem_addr];
  assign dmem_ack   = dmem_req && (dmem_cnt >= dmem_lat);
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!dmem_req || dmem_ack) dmem_cnt <= 0;
    else                       dmem_cnt <= dmem_cnt + 1;
  end

  always @(negedge clk) begin
    if (reset && imem_req && imem_ack) begin
      f_addr.push_back(imem_addr);
      f_cyc.push_back(cyc);
    end
    if (reset && dmem_req && dmem_we && dmem_ack) begin
      w_addr.push_back(dmem_addr);
      w_data.push_back(dmem_wdata);
      w_carry.push_back(carry);
    end
  end

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 256; i++) imem[i] = v;
    for (int i = 0; i < 16; i++) dmem[i] = 8'h00;
    dmem_lat = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    f_addr.delete(); f_cyc.delete();
    w_addr.delete(); w_data.delete(); w_carry.delete();
    reset = 1'b1;
  endtask

  task automatic wait_halt(input string name);
    for (int i = 0; i < 200 && !halted; i++) @(negedge clk);
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL %s halt-timeout: halted=%b required 1", name, halted);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if ({imem_req, dmem_req, halted, carry} !== 4'b0000 || imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: req/dreq/halt/carry=%b addr=%h required 0000 00",
               {imem_req, dmem_req, halted, carry}, imem_addr);
    end
  endtask

  task automatic test_nop_fetch();
    fill(8'h00);
    do_reset();
    repeat (8) @(negedge clk);
    checks++;
    if (f_addr.size() < 3) begin
      errors++;
      $display("FAIL nop_fetch_count: got %0d fetches required >=3", f_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (f_addr[i] !== 8'(i)) begin
          errors++;
          $display("FAIL nop_fetch_addr%0d: got %h required %h", i, f_addr[i], 8'(i));
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (f_cyc[i] - f_cyc[i-1] != 2) begin
          errors++;
          $display("FAIL nop_fetch_spacing%0d: got %0d required 2", i, f_cyc[i] - f_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_ld_add_st();
    fill(8'h10);
    imem[0] = 8'h43; imem[1] = 8'h54; imem[2] = 8'hC1; imem[3] = 8'hB5;
    dmem[3] = 8'h7F; dmem[4] = 8'h01;
    do_reset();
    wait_halt("ld_add_st");
    checks++;
    if (w_addr.size() != 1 || w_addr[0] !== 4'd5 || w_data[0] !== 8'h80 || carry !== 1'b0) begin
      errors++;
      $display("FAIL ld_add_st: writes=%0d addr=%h data=%h carry=%b required 1 5 80 0",
               w_addr.size(), w_addr.size() ? w_addr[0] : 4'hx,
               w_data.size() ? w_data[0] : 8'hxx, carry);
    end
  endtask

  task automatic test_carry();
    logic [7:0] exp_d1;
    logic       exp_c;
`ifdef SMALL_CPU_CARRY_EN
    exp_d1 = 8'hFF; exp_c = 1'b1;
`else
    exp_d1 = 8'hFE; exp_c = 1'b0;
`endif
    fill(8'h10);
    imem[0] = 8'h40; imem[1] = 8'h50; imem[2] = 8'hC1; imem[3] = 8'hB1;
    imem[4] = 8'hC1; imem[5] = 8'hB2;
    dmem[0] = 8'hFF;
    do_reset();
    wait_halt("carry");
    checks++;
    if (w_addr.size() != 2) begin
      errors++;
      $display("FAIL carry_writes: got %0d required 2", w_addr.size());
    end else begin
      checks++;
      if (w_data[0] !== 8'hFE || w_carry[0] !== exp_c) begin
        errors++;
        $display("FAIL carry_add1: r3=%h carry=%b required FE %b", w_data[0], w_carry[0], exp_c);
      end
      checks++;
      if (w_data[1] !== exp_d1 || carry !== exp_c) begin
        errors++;
        $display("FAIL carry_add2: r3=%h carry=%b required %h %b", w_data[1], carry, exp_d1, exp_c);
      end
    end
  endtask

  task automatic test_jumps();
    logic [7:0] exp_j[3];
    exp_j[0] = 8'h00; exp_j[1] = 8'hFF; exp_j[2] = 8'hFE;
    fill(8'h10);
    imem[0] = 8'h2E; imem[8'hFF] = 8'h2E;
    do_reset();
    wait_halt("jmp");
    checks++;
    if (f_addr.size() != 3) begin
      errors++;
      $display("FAIL jmp_count: got %0d fetches required 3", f_addr.size());
    end else
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (f_addr[i] !== exp_j[i]) begin
          errors++;
          $display("FAIL jmp_fetch%0d: got %h required %h", i, f_addr[i], exp_j[i]);
        end
      end
    // JZ with r3=1 falls through
    fill(8'h10);
    imem[0] = 8'h70; imem[1] = 8'h35;
    dmem[0] = 8'h01;
    do_reset();
    wait_halt("jz_nt");
    checks++;
    if (f_addr.size() != 3 || f_addr[2] !== 8'h02) begin
      errors++;
      $display("FAIL jz_not_taken: fetches=%0d last=%h required 3 02",
               f_addr.size(), f_addr.size() ? f_addr[f_addr.size()-1] : 8'hxx);
    end
    // JZ with r3=0 (post-reset) is taken: 1 + 2 = 3
    fill(8'h10);
    imem[0] = 8'h32;
    do_reset();
    wait_halt("jz_t");
    checks++;
    if (f_addr.size() != 2 || f_addr[1] !== 8'h03) begin
      errors++;
      $display("FAIL jz_taken: fetches=%0d last=%h required 2 03",
               f_addr.size(), f_addr.size() ? f_addr[f_addr.size()-1] : 8'hxx);
    end
  endtask

  task automatic test_dmem_stall();
    fill(8'h10);
    imem[0] = 8'h49; imem[1] = 8'h8A;
    dmem[9] = 8'h5A;
    do_reset();
    dmem_lat = 5;
    for (int i = 0; i < 50 && !dmem_req; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({dmem_req, dmem_we, dmem_ack, imem_req} !== 4'b1000 || dmem_addr !== 4'h9) begin
        errors++;
        $display("FAIL stall_cycle%0d: req/we/ack/ireq=%b addr=%h required 1000 9",
                 i, {dmem_req, dmem_we, dmem_ack, imem_req}, dmem_addr);
      end
      @(negedge clk);
    end
    checks++;
    if (dmem_ack !== 1'b1) begin
      errors++;
      $display("FAIL stall_ack: got %b required 1", dmem_ack);
    end
    dmem_lat = 0;
    wait_halt("stall");
    checks++;
    if (w_addr.size() != 1 || w_addr[0] !== 4'hA || w_data[0] !== 8'h5A) begin
      errors++;
      $display("FAIL stall_load_data: writes=%0d data=%h required 1 5A",
               w_addr.size(), w_data.size() ? w_data[0] : 8'hxx);
    end
  endtask

  task automatic test_reset_mid_access();
    fill(8'h10);
    imem[0] = 8'h49;
    do_reset();
    dmem_lat = 5;
    for (int i = 0; i < 50 && !dmem_req; i++) @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({dmem_req, imem_req, imem_addr} !== 10'b0) begin
      errors++;
      $display("FAIL reset_abort: dreq=%b ireq=%b pc=%h required 0 0 00", dmem_req, imem_req, imem_addr);
    end
    @(negedge clk);
    dmem_lat = 0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_refetch: ireq=%b addr=%h required 1 00", imem_req, imem_addr);
    end
  endtask

  task automatic test_halt();
    int reqs;
    fill(8'h10);
    do_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_exec: halted=%b required 0", halted);
    end
    @(posedge clk); #1;
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_set: halted=%b required 1", halted);
    end
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req || dmem_req || !halted) reqs++;
    end
    checks++;
    if (reqs != 0) begin
      errors++;
      $display("FAIL halt_hold: %0d bad cycles required 0", reqs);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_clear: halted=%b required 0", halted);
    end
  endtask

  initial begin
    test_reset();
    test_nop_fetch();
    test_ld_add_st();
    test_carry();
    test_jumps();
    test_dmem_stall();
    test_reset_mid_access();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
